axi4_slave_arbiter: RTL and testbench
=====================================

// Module: axi4_slave_arbiter
// PURPOSE
//  Two-master arbiter that shares a single AXI4 memory slave port between requesters m0 and m1.
//  Write path (AW+W+B) and read path (AR+R) are arbitrated independently, each round-robin.
//  Each path has one transaction outstanding at a time.
//  Sits between two bus masters and the 256-word memory slave; slave-side signals are named s_*.
// PARAMETERS
//  ADDR_W  32  address width, all AW/AR buses
//  DATA_W  32  data width, all W/R buses
//  CNT_W   16  width of grant statistics counters (ARB_STATS_EN only)
// PORTS
//  clk                        in   1       clock, all logic posedge
//  reset_n                    in   1       async active-low reset
//  m0_/m1_awaddr              in   ADDR_W  master write address
//  m0_/m1_awvalid             in   1       master write address valid
//  m0_/m1_awready             out  1       write address accepted
//  m0_/m1_wdata               in   DATA_W  master write data
//  m0_/m1_wvalid              in   1       master write data valid
//  m0_/m1_wready              out  1       write data accepted
//  m0_/m1_bvalid              out  1       write response valid
//  m0_/m1_bready              in   1       write response accept
//  m0_/m1_araddr              in   ADDR_W  master read address
//  m0_/m1_arvalid             in   1       master read address valid
//  m0_/m1_arready             out  1       read address accepted
//  m0_/m1_rdata               out  DATA_W  read data (= s_rdata when granted, else 0)
//  m0_/m1_rvalid              out  1       read data valid
//  m0_/m1_rready              in   1       read data accept
//  s_awaddr,s_awvalid         out  ADDR_W,1  to slave
//  s_awready                  in   1
//  s_wdata,s_wvalid           out  DATA_W,1  to slave
//  s_wready                   in   1
//  s_bvalid                   in   1;  s_bready  out  1
//  s_araddr,s_arvalid         out  ADDR_W,1  to slave
//  s_arready                  in   1
//  s_rdata                    in   DATA_W
//  s_rvalid                   in   1;  s_rready  out  1
//  wr_gnt_cnt0/1,rd_gnt_cnt0/1  out  CNT_W  grants issued per master/path
// BEHAVIOUR
//  Reset (async, reset_n=0): both FSMs -> IDLE; rr pointers select m0 first.
//    All valid/ready outputs 0; counters 0.
//  Write FSM: WR_IDLE -> WR_XFER -> WR_RESP -> WR_IDLE.
//    WR_IDLE: request = mX_awvalid. If both request, grant the master not granted last.
//      Grant registered; forwarding starts next cycle (1-cycle arbitration latency).
//    WR_XFER: s_aw* = granted m_aw*; s_w* = granted m_w*; slave readies routed back to granted master only.
//      aw_done/w_done flags set on each handshake; s_awvalid/s_wvalid drop after own handshake.
//      Leave for WR_RESP when both flags set (same cycle allowed).
//    WR_RESP: granted mX_bvalid = s_bvalid; s_bready = granted mX_bready.
//      On handshake -> WR_IDLE; toggle rr pointer.
//  Read FSM: RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE.
//    Same round-robin rule on mX_arvalid.
//    RD_ADDR forwards AR until s_arready.
//    RD_DATA forwards s_rdata/s_rvalid; exits on rvalid&rready handshake.
//  Non-granted master: all its ready/valid outputs 0; its requests are held pending, never dropped.
//  Read and write paths are fully concurrent; the same master may own both.
//  A master deasserting valid before its handshake is a protocol violation; behaviour is undefined.
//  Reset mid-transaction: abort immediately; no response is replayed.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    Counters +1 on each grant (registered in the IDLE state), saturating at all-ones.
//  ARB_STATS_EN undefined:
//    Counter ports driven constant 0; no counter flops.
// TESTING
//  m0 write addr 0x10 data 0xA5A5A5A5 alone -> s_awaddr=0x10; m0_bvalid once; m1 outputs stay 0.
//  m0+m1 write same cycle after reset -> m0 served first, then m1; next tie -> m0 again (alternation).
//  m0 read 0x10 while m1 writes 0x20 -> both paths progress concurrently; m0_rdata=0xA5A5A5A5.
//  Hold m0_bready=0 for 5 cycles -> write FSM stays WR_RESP; m1 write waits; read path unaffected.
//  reset_n low during WR_XFER -> all valids/readies 0 same cycle; next request granted cleanly.
//  ARB_STATS_EN: 3 m0 writes + 2 m1 reads -> wr_gnt_cnt0=3, rd_gnt_cnt1=2; CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/axi4_slave_arbiter.sv
// Round-robin arbiter sharing one AXI4 slave port between masters m0 and m1.
// Optional grant statistics counters are enabled by defining ARB_STATS_EN.
module axi4_slave_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [CNT_W-1:0]  wr_gnt_cnt0,
  output logic [CNT_W-1:0]  wr_gnt_cnt1,
  output logic [CNT_W-1:0]  rd_gnt_cnt0,
  output logic [CNT_W-1:0]  rd_gnt_cnt1
);

  typedef enum logic [1:0] {WrIdle, WrXfer, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  // *_gnt: owning master index; *_rr: master preferred on the next tie
  logic wr_gnt_q, wr_gnt_d, wr_rr_q, wr_rr_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd_gnt_q, rd_gnt_d, rd_rr_q, rd_rr_d;
  logic wr_xfer, wr_resp, aw_hs, w_hs, b_hs;
  logic rd_addr, rd_data, rd_busy, ar_hs, r_hs;

  assign wr_xfer = (wr_state_q == WrXfer);
  assign wr_resp = (wr_state_q == WrResp);
  assign rd_addr = (rd_state_q == RdAddr);
  assign rd_data = (rd_state_q == RdData);
  assign rd_busy = (rd_state_q != RdIdle);

  // Write path forwarding
  assign s_awaddr   = wr_gnt_q ? m1_awaddr : m0_awaddr;
  assign s_wdata    = wr_gnt_q ? m1_wdata : m0_wdata;
  assign s_awvalid  = wr_xfer && !aw_done_q && (wr_gnt_q ? m1_awvalid : m0_awvalid);
  assign s_wvalid   = wr_xfer && !w_done_q && (wr_gnt_q ? m1_wvalid : m0_wvalid);
  assign s_bready   = wr_resp && (wr_gnt_q ? m1_bready : m0_bready);
  assign m0_awready = wr_xfer && !wr_gnt_q && !aw_done_q && s_awready;
  assign m1_awready = wr_xfer && wr_gnt_q && !aw_done_q && s_awready;
  assign m0_wready  = wr_xfer && !wr_gnt_q && !w_done_q && s_wready;
  assign m1_wready  = wr_xfer && wr_gnt_q && !w_done_q && s_wready;
  assign m0_bvalid  = wr_resp && !wr_gnt_q && s_bvalid;
  assign m1_bvalid  = wr_resp && wr_gnt_q && s_bvalid;
  assign aw_hs      = s_awvalid && s_awready;
  assign w_hs       = s_wvalid && s_wready;
  assign b_hs       = s_bready && s_bvalid;

  // Read path forwarding
  assign s_araddr   = rd_gnt_q ? m1_araddr : m0_araddr;
  assign s_arvalid  = rd_addr && (rd_gnt_q ? m1_arvalid : m0_arvalid);
  assign s_rready   = rd_data && (rd_gnt_q ? m1_rready : m0_rready);
  assign m0_arready = rd_addr && !rd_gnt_q && s_arready;
  assign m1_arready = rd_addr && rd_gnt_q && s_arready;
  assign m0_rvalid  = rd_data && !rd_gnt_q && s_rvalid;
  assign m1_rvalid  = rd_data && rd_gnt_q && s_rvalid;
  assign m0_rdata   = (rd_busy && !rd_gnt_q) ? s_rdata : '0;
  assign m1_rdata   = (rd_busy && rd_gnt_q) ? s_rdata : '0;
  assign ar_hs      = s_arvalid && s_arready;
  assign r_hs       = s_rvalid && s_rready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= WrIdle;
      wr_gnt_q   <= 1'b0;
      wr_rr_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= RdIdle;
      rd_gnt_q   <= 1'b0;
      rd_rr_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_rr_q    <= wr_rr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_rr_q    <= rd_rr_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_rr_d    = wr_rr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (m0_awvalid || m1_awvalid) begin
          wr_gnt_d   = (m0_awvalid && m1_awvalid) ? wr_rr_q : m1_awvalid;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WrXfer;
        end
      end
      WrXfer: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) w_done_d = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = WrResp;
      end
      WrResp: begin
        if (b_hs) begin
          wr_state_d = WrIdle;
          wr_rr_d    = !wr_gnt_q;
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_rr_d    = rd_rr_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (m0_arvalid || m1_arvalid) begin
          rd_gnt_d   = (m0_arvalid && m1_arvalid) ? rd_rr_q : m1_arvalid;
          rd_state_d = RdAddr;
        end
      end
      RdAddr: begin
        if (ar_hs) rd_state_d = RdData;
      end
      RdData: begin
        if (r_hs) begin
          rd_state_d = RdIdle;
          rd_rr_d    = !rd_gnt_q;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_q [4];

  assign cnt_inc[0] = (wr_state_q == WrIdle) && (m0_awvalid || m1_awvalid) && !wr_gnt_d;
  assign cnt_inc[1] = (wr_state_q == WrIdle) && (m0_awvalid || m1_awvalid) && wr_gnt_d;
  assign cnt_inc[2] = (rd_state_q == RdIdle) && (m0_arvalid || m1_arvalid) && !rd_gnt_d;
  assign cnt_inc[3] = (rd_state_q == RdIdle) && (m0_arvalid || m1_arvalid) && rd_gnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign wr_gnt_cnt0 = cnt_q[0];
  assign wr_gnt_cnt1 = cnt_q[1];
  assign rd_gnt_cnt0 = cnt_q[2];
  assign rd_gnt_cnt1 = cnt_q[3];
`else
  assign wr_gnt_cnt0 = '0;
  assign wr_gnt_cnt1 = '0;
  assign rd_gnt_cnt0 = '0;
  assign rd_gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_axi4_slave_arbiter.sv
// Directed bench for axi4_slave_arbiter with a small 256-word memory slave model.
module tb_axi4_slave_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr_m [2];
  logic [31:0] wdata_m  [2];
  logic [31:0] araddr_m [2];
  logic        awvalid_m [2];
  logic        wvalid_m  [2];
  logic        bready_m  [2];
  logic        arvalid_m [2];
  logic        rready_m  [2];
  wire         awready0, awready1, wready0, wready1, bvalid0, bvalid1;
  wire         arready0, arready1, rvalid0, rvalid1;
  wire  [31:0] rdata0, rdata1;

  wire  [31:0] s_awaddr, s_wdata, s_araddr;
  wire         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        s_awready = 1'b1;
  logic        s_wready  = 1'b1;
  logic        s_arready = 1'b1;
  logic        s_bvalid, s_rvalid;
  logic [31:0] s_rdata;
  wire  [15:0] wr_gnt_cnt0, wr_gnt_cnt1, rd_gnt_cnt0, rd_gnt_cnt1;

  axi4_slave_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_awaddr(awaddr_m[0]), .m0_awvalid(awvalid_m[0]), .m0_awready(awready0),
    .m0_wdata(wdata_m[0]), .m0_wvalid(wvalid_m[0]), .m0_wready(wready0),
    .m0_bvalid(bvalid0), .m0_bready(bready_m[0]),
    .m0_araddr(araddr_m[0]), .m0_arvalid(arvalid_m[0]), .m0_arready(arready0),
    .m0_rdata(rdata0), .m0_rvalid(rvalid0), .m0_rready(rready_m[0]),
    .m1_awaddr(awaddr_m[1]), .m1_awvalid(awvalid_m[1]), .m1_awready(awready1),
    .m1_wdata(wdata_m[1]), .m1_wvalid(wvalid_m[1]), .m1_wready(wready1),
    .m1_bvalid(bvalid1), .m1_bready(bready_m[1]),
    .m1_araddr(araddr_m[1]), .m1_arvalid(arvalid_m[1]), .m1_arready(arready1),
    .m1_rdata(rdata1), .m1_rvalid(rvalid1), .m1_rready(rready_m[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_gnt_cnt0(wr_gnt_cnt0), .wr_gnt_cnt1(wr_gnt_cnt1),
    .rd_gnt_cnt0(rd_gnt_cnt0), .rd_gnt_cnt1(rd_gnt_cnt1)
  );

  // Memory slave model: one write and one read in flight, word-addressed by addr[9:2]
  logic [31:0] mem [256];
  logic [31:0] aw_q, w_q;
  logic        have_aw, have_w;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_aw  <= 1'b0;
      have_w   <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
    end else begin
      if (s_awvalid && s_awready) begin
        have_aw <= 1'b1;
        aw_q    <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        have_w <= 1'b1;
        w_q    <= s_wdata;
      end
      if (have_aw && have_w && !s_bvalid) begin
        mem[aw_q[9:2]] <= w_q;
        s_bvalid       <= 1'b1;
        have_aw        <= 1'b0;
        have_w         <= 1'b0;
      end
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[s_araddr[9:2]];
      end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
    end
  end

  logic [31:0] aw_log [$];
  always @(posedge clk) if (reset_n && s_awvalid && s_awready) aw_log.push_back(s_awaddr);

  int m1_act = 0;
  int b0_hs = 0;
  int both_act = 0;
  always @(negedge clk) begin
    if (awready1 || wready1 || bvalid1 || arready1 || rvalid1 || (rdata1 != 0)) m1_act++;
    if (bvalid0 && bready_m[0]) b0_hs++;
    if (s_awvalid && s_arvalid) both_act++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic awr(input int m); return (m != 0) ? awready1 : awready0; endfunction
  function automatic logic wr_(input int m); return (m != 0) ? wready1 : wready0; endfunction
  function automatic logic bv(input int m); return (m != 0) ? bvalid1 : bvalid0; endfunction
  function automatic logic arr(input int m); return (m != 0) ? arready1 : arready0; endfunction
  function automatic logic rv(input int m); return (m != 0) ? rvalid1 : rvalid0; endfunction
  function automatic logic [31:0] rd(input int m); return (m != 0) ? rdata1 : rdata0; endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input int bhold, output time done_t);
    logic aw_f, w_f;
    int   n;
    @(posedge clk);
    #1;
    awaddr_m[m] = addr; wdata_m[m] = data;
    awvalid_m[m] = 1'b1; wvalid_m[m] = 1'b1; bready_m[m] = 1'b0;
    n = 0;
    while ((awvalid_m[m] || wvalid_m[m]) && n < 200) begin
      @(negedge clk);
      aw_f = awvalid_m[m] && awr(m);
      w_f  = wvalid_m[m] && wr_(m);
      @(posedge clk);
      #1;
      if (aw_f) awvalid_m[m] = 1'b0;
      if (w_f) wvalid_m[m] = 1'b0;
      n++;
    end
    check("wr_xfer_done", {awvalid_m[m], wvalid_m[m]}, 0);
    n = 0;
    @(negedge clk);
    while (!bv(m) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wr_bvalid_seen", bv(m), 1);
    if (bhold > 0) begin
      repeat (bhold) @(negedge clk);
      check("wr_b_hold", bv(m), 1);
    end
    @(posedge clk);
    #1 bready_m[m] = 1'b1;
    @(posedge clk);
    done_t = $time;
    #1 bready_m[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input logic [31:0] addr, output logic [31:0] data,
                         output time done_t);
    logic ar_f;
    int   n;
    @(posedge clk);
    #1;
    araddr_m[m] = addr; arvalid_m[m] = 1'b1; rready_m[m] = 1'b1;
    n = 0;
    while (arvalid_m[m] && n < 200) begin
      @(negedge clk);
      ar_f = arr(m);
      @(posedge clk);
      #1;
      if (ar_f) arvalid_m[m] = 1'b0;
      n++;
    end
    check("rd_ar_done", arvalid_m[m], 0);
    n = 0;
    @(negedge clk);
    while (!rv(m) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rd_rvalid_seen", rv(m), 1);
    data = rd(m);
    @(posedge clk);
    done_t = $time;
    #1 rready_m[m] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  time         t0, t1, t2;
  logic [31:0] d0, d1;
  int          base, a0, b0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      awaddr_m[i] = '0; wdata_m[i] = '0; araddr_m[i] = '0;
      awvalid_m[i] = 0; wvalid_m[i] = 0; bready_m[i] = 0; arvalid_m[i] = 0; rready_m[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slave_valids", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 0);
    check("rst_m_readies", {awready0, wready0, arready0, awready1, wready1, arready1}, 0);
    check("rst_counters", {wr_gnt_cnt0, wr_gnt_cnt1, rd_gnt_cnt0, rd_gnt_cnt1}, 0);
    #1 reset_n = 1'b1;

    // Single m0 write; one cycle of arbitration latency before forwarding
    a0 = m1_act; b0 = b0_hs;
    fork
      do_write(0, 32'h10, 32'hA5A5_A5A5, 0, t0);
      begin
        @(posedge clk);
        @(negedge clk);
        check("arb_latency_idle", s_awvalid, 0);
        @(negedge clk);
        check("fwd_awvalid", s_awvalid, 1);
        check("fwd_awaddr", s_awaddr, 32'h10);
        check("fwd_wdata", s_wdata, 32'hA5A5_A5A5);
      end
    join
    repeat (2) @(negedge clk);
    check("solo_slave_awaddr", aw_log[aw_log.size()-1], 32'h10);
    check("solo_b_once", b0_hs - b0, 1);
    check("solo_m1_quiet", m1_act - a0, 0);

    // Ties alternate, m0 first after reset
    do_reset();
    base = aw_log.size();
    fork
      do_write(0, 32'h20, 32'h1, 0, t0);
      do_write(1, 32'h24, 32'h2, 0, t1);
    join
    fork
      do_write(0, 32'h28, 32'h3, 0, t0);
      do_write(1, 32'h2C, 32'h4, 0, t1);
    join
    check("tie_count", aw_log.size() - base, 4);
    check("tie1_first_m0", aw_log[base], 32'h20);
    check("tie1_then_m1", aw_log[base+1], 32'h24);
    check("tie2_first_m0", aw_log[base+2], 32'h28);
    check("tie2_then_m1", aw_log[base+3], 32'h2C);

    // Concurrent read (m0) and write (m1)
    a0 = both_act;
    fork
      do_read(0, 32'h10, d0, t0);
      do_write(1, 32'h20, 32'h55, 0, t1);
    join
    check("conc_rdata", d0, 32'hA5A5_A5A5);
    check("conc_overlap", (both_act > a0), 1);
    do_read(1, 32'h20, d1, t2);
    check("conc_wdata_back", d1, 32'h55);

    // m0 holds bready low; m1 write waits, m1 read proceeds
    base = aw_log.size();
    fork
      do_write(0, 32'h30, 32'h33, 5, t0);
      begin
        repeat (2) @(posedge clk);
        fork
          do_write(1, 32'h34, 32'h44, 0, t1);
          do_read(1, 32'h10, d1, t2);
        join
      end
    join
    check("hold_rd_before_b", (t2 < t0), 1);
    check("hold_wr_after_b", (t1 > t0), 1);
    check("hold_rdata", d1, 32'hA5A5_A5A5);
    check("hold_order", aw_log[base+1], 32'h34);

    // Reset during WR_XFER aborts immediately
    s_awready = 1'b0; s_wready = 1'b0;
    @(posedge clk);
    #1;
    awaddr_m[0] = 32'h50; wdata_m[0] = 32'hDEAD; awvalid_m[0] = 1; wvalid_m[0] = 1;
    repeat (2) @(negedge clk);
    check("xfer_stalled", {s_awvalid, s_wvalid}, 2'b11);
    reset_n = 1'b0;
    #1;
    check("rst_abort_valids", {s_awvalid, s_wvalid, s_bready, bvalid0}, 0);
    awvalid_m[0] = 0; wvalid_m[0] = 0;
    s_awready = 1'b1; s_wready = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    do_write(1, 32'h40, 32'hCAFE, 0, t1);
    check("post_rst_awaddr", aw_log[aw_log.size()-1], 32'h40);
    do_read(0, 32'h40, d0, t2);
    check("post_rst_data", d0, 32'hCAFE);

`ifdef ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) do_write(0, 32'h60 + 4 * i, i, 0, t0);
    for (int i = 0; i < 2; i++) do_read(1, 32'h60, d1, t2);
    @(negedge clk);
    check("stat_wr0", wr_gnt_cnt0, 3);
    check("stat_rd1", rd_gnt_cnt1, 2);
    check("stat_wr1", wr_gnt_cnt1, 0);
    check("stat_rd0", rd_gnt_cnt0, 0);
`else
    @(negedge clk);
    check("stat_off_zero", {wr_gnt_cnt0, wr_gnt_cnt1, rd_gnt_cnt0, rd_gnt_cnt1}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
